// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift unit: widths, op codes, FSM encoding.
`default_nettype none

package shift_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int SHAMT_W_DEF = 5;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_down_counter.sv
// Loadable down-counter with zero flag; decrement saturates at zero.
`default_nettype none

module shift_down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_cnt,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;
  logic         w_zero;

  assign w_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_cnt;
    end else if (i_dec && !w_zero) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = w_zero;

endmodule

`default_nettype wire

// File: rtl/serial_shift_unit.sv
// Multi-cycle RV32I shifter: one bit per cycle, fixed latency of shamt+2 cycles
// from accepted start to the done pulse.
`default_nettype none

module serial_shift_unit
  import shift_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result
);

  state_e              r_state;
  state_e              w_next;
  logic [XLEN-1:0]     r_work;
  logic [XLEN-1:0]     w_work_shift;
  logic [XLEN-1:0]     r_result;
  logic [1:0]          r_op;
  logic [SHAMT_W-1:0]  w_cnt;
  logic                w_zero;
  logic                w_load;
  logic                w_dec;
  logic                w_done;

  assign w_load = (r_state == ST_IDLE) && start && !flush;
  assign w_dec  = (r_state == ST_SHIFT) && !flush;

  shift_down_counter #(
    .W (SHAMT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_dec  (w_dec),
    .i_cnt  (shamt),
    .o_cnt  (w_cnt),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_SHIFT;
      ST_SHIFT: if (w_zero) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (flush) begin
      w_next = ST_IDLE;
    end
  end

  // Reserved op holds the value but still burns the count, keeping latency uniform.
  always_comb begin
    w_work_shift = r_work;
    case (r_op)
      OP_SLL:  w_work_shift = {r_work[XLEN-2:0], 1'b0};
      OP_SRL:  w_work_shift = {1'b0, r_work[XLEN-1:1]};
      OP_SRA:  w_work_shift = {r_work[XLEN-1], r_work[XLEN-1:1]};
      default: w_work_shift = r_work;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_work <= '0;
      r_op   <= OP_SLL;
    end else if (w_load) begin
      r_work <= operand;
      r_op   <= op;
    end else if (w_dec && !w_zero) begin
      r_work <= w_work_shift;
    end
  end

  assign w_done = (r_state == ST_DONE) && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= '0;
    end else if (w_done) begin
      r_result <= r_work;
    end
  end

  // The new value is visible during the done cycle itself so the core can take it on done.
  assign result = w_done ? r_work : r_result;
  assign done   = w_done;
  assign busy   = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_shift_unit.sv
// Scoreboard bench for serial_shift_unit: directed cases plus randomized traffic.
`default_nettype none

module tb_serial_shift_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  serial_shift_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .operand (operand),
    .shamt   (shamt),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  typedef struct {
    logic [31:0] res;
    int          dc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          m_lo = 1;
  int          m_hi = 0;
  int          free_edge = 0;
  logic [31:0] m_result = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a, input int s);
    case (o)
      2'd0:    return a << s;
      2'd1:    return a >> s;
      2'd2:    return 32'($signed(a) >>> s);
      default: return a;
    endcase
  endfunction

  // Drives inputs seen at the next rising edge and updates the reference timeline.
  task automatic step(input bit st, input logic [1:0] o, input logic [31:0] a,
                      input logic [4:0] s, input bit fl);
    int e;
    exp_t x;
    e = cyc + 1;
    start = st; op = o; operand = a; shamt = s; flush = fl;
    if (fl) begin
      if (q.size() > 0 && q[$].dc >= e - 1) void'(q.pop_back());
      if (m_hi >= e) m_hi = e - 1;
      free_edge = e + 1;
    end else if (st && e >= free_edge) begin
      x.res = ref_shift(o, a, int'(s));
      x.dc  = e + int'(s) + 1;
      q.push_back(x);
      m_lo = e;
      m_hi = e + int'(s) + 1;
      free_edge = e + int'(s) + 3;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'd0, 32'h0, 5'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   exp_busy;
    if (rst) begin
      exp_busy = (cyc >= m_lo) && (cyc <= m_hi);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy @%0d: got %b expected %b", cyc, busy, exp_busy);
      end
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done @%0d: got done=1 expected done=0", cyc);
        end else begin
          e = q.pop_front();
          checks += 2;
          if (result !== e.res) begin
            errors++;
            $display("FAIL done_result @%0d: got %h expected %h", cyc, result, e.res);
          end
          if (cyc != e.dc) begin
            errors++;
            $display("FAIL done_cycle: got %0d expected %0d", cyc, e.dc);
          end
          m_result = e.res;
        end
      end else begin
        checks++;
        if (result !== m_result) begin
          errors++;
          $display("FAIL result_hold @%0d: got %h expected %h", cyc, result, m_result);
        end
        if (q.size() > 0 && q[0].dc <= cyc) begin
          checks++; errors++;
          $display("FAIL missing_done @%0d: got done=0 expected done=1 result %h", cyc, q[0].res);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'd0; operand = 32'h0; shamt = 5'd0; flush = 1'b0;
    @(posedge clk); #1;
    checks += 3;
    if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    rst = 1'b1;
    idle(2);

    step(1'b1, 2'd0, 32'h0000_0001, 5'd4, 1'b0);  idle(8);
    step(1'b1, 2'd2, 32'h8000_0000, 5'd31, 1'b0); idle(34);
    step(1'b1, 2'd1, 32'h8000_0000, 5'd31, 1'b0); idle(34);
    step(1'b1, 2'd1, 32'hDEAD_BEEF, 5'd0, 1'b0);  idle(4);

    // Second start while busy is dropped.
    step(1'b1, 2'd0, 32'h0000_0001, 5'd8, 1'b0); idle(2);
    step(1'b1, 2'd1, 32'h0000_00FF, 5'd8, 1'b0); idle(10);

    // Flush mid-shift, then a fresh start on the following edge.
    step(1'b1, 2'd1, 32'h0000_00F0, 5'd10, 1'b0); idle(3);
    step(1'b0, 2'd0, 32'h0, 5'd0, 1'b1);
    step(1'b1, 2'd3, 32'h1234_5678, 5'd3, 1'b0);  idle(7);

    // Start on the DONE->IDLE edge is ignored, accepted one edge later.
    step(1'b1, 2'd0, 32'h0000_0003, 5'd2, 1'b0); idle(3);
    step(1'b1, 2'd1, 32'hFFFF_0000, 5'd4, 1'b0);
    step(1'b1, 2'd2, 32'hF000_0000, 5'd4, 1'b0); idle(8);

    // Flush during the DONE cycle suppresses completion.
    step(1'b1, 2'd0, 32'h0000_0005, 5'd1, 1'b0); idle(2);
    step(1'b0, 2'd0, 32'h0, 5'd0, 1'b1); idle(3);

    // Asynchronous reset between edges in the middle of a shift.
    step(1'b1, 2'd0, 32'hA5A5_A5A5, 5'd20, 1'b0); idle(5);
    #2 rst = 1'b0;
    q.delete(); m_result = 32'h0; m_lo = 1; m_hi = 0; free_edge = 0;
    #1;
    checks += 3;
    if (busy !== 1'b0)   begin errors++; $display("FAIL async_busy: got %b expected 0", busy); end
    if (done !== 1'b0)   begin errors++; $display("FAIL async_done: got %b expected 0", done); end
    if (result !== 32'h0) begin errors++; $display("FAIL async_result: got %h expected 0", result); end
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b1, 2'd0, 32'h0000_0001, 5'd4, 1'b0); idle(8);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] s;
      s = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      step($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom, s,
           $urandom_range(0, 19) == 0);
    end
    idle(40);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
